// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin scheduler feeding one shared, programmable,
// overlapping bit-pattern detector that serves NCH serial channels. Each
// channel keeps its own history and fill count, so a channel picks up where
// it left off after waiting for its turn.
module seq_det_sched #(
    parameter int  NCH    = 4,
    parameter int  MAXLEN = 8,
    parameter int  CW     = 16,
    localparam int CHW    = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [3:0]        cfg_len,
    input  logic              en,
    input  logic [NCH-1:0]    ch_valid,
    input  logic [NCH-1:0]    ch_bit,
    output logic [NCH-1:0]    ch_ready,
    output logic              det_valid,
    output logic [CHW-1:0]    det_ch,
    output logic [CW-1:0]     match_cnt,
    output logic              cfg_err,
    output logic              busy
);

    typedef enum logic [1:0] {S_UNCFG, S_IDLE, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [CHW-1:0]    ptr_q;
    logic [MAXLEN-1:0] pat_q;
    logic [3:0]        len_q;
    logic [MAXLEN-1:0] hist_q [NCH];
    logic [3:0]        fill_q [NCH];

    logic              cfg_legal;
    logic              grant_vld;
    logic [CHW-1:0]    grant_idx;
    logic [CHW-1:0]    ptr_next;
    logic [MAXLEN-1:0] len_mask;
    logic [MAXLEN-1:0] new_hist;
    logic [3:0]        new_fill;
    logic              match;

    assign cfg_legal = cfg_we && (cfg_len != 4'd0) && (cfg_len <= 4'(MAXLEN));
    assign busy      = (state_q == S_RUN);

    // Mode register: UNCFG until the first legal configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_UNCFG;
        else     state_q <= state_d;
    end

    // Next-state: any configuration write wins over en; a rejected one holds the mode.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        if (cfg_we) begin
            if (cfg_legal) state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (en)  state_d = S_RUN;
                S_RUN:   if (!en) state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Round-robin grant: first valid channel at or after the pointer, only in RUN and never during a config write.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        ch_ready  = '0;
        if (state_q == S_RUN && !cfg_we) begin
            // Scan from the farthest offset down so the nearest valid channel is the one left standing.
            for (int k = NCH - 1; k >= 0; k--) begin
                if (ch_valid[(int'(ptr_q) + k) % NCH]) begin
                    grant_vld = 1'b1;
                    grant_idx = CHW'((int'(ptr_q) + k) % NCH);
                end
            end
            ch_ready[grant_idx] = grant_vld;
        end
        ptr_next = (grant_idx == CHW'(NCH - 1)) ? '0 : grant_idx + CHW'(1);
    end

    // Shared detector: shift the granted bit into that channel's history and compare the low len bits.
    always_comb begin
        for (int i = 0; i < MAXLEN; i++) len_mask[i] = (4'(i) < len_q);
        new_hist = {hist_q[grant_idx][MAXLEN-2:0], ch_bit[grant_idx]};
        new_fill = (fill_q[grant_idx] >= len_q) ? len_q : fill_q[grant_idx] + 4'd1;
        match    = grant_vld && (new_fill == len_q) && (((new_hist ^ pat_q) & len_mask) == '0);
    end

    // Datapath state: pointer, per-channel histories, match reporting and configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            det_valid <= 1'b0;
            det_ch    <= '0;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
            // NOTE: the histories are small flop arrays whose zero state is architectural, so they are reset explicitly rather than left as uninitialised memory.
            for (int c = 0; c < NCH; c++) begin
                hist_q[c] <= '0;
                fill_q[c] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every read above sees pre-edge values regardless of statement order.
            det_valid <= match;
            cfg_err   <= cfg_we && !cfg_legal;
            if (grant_vld) begin
                ptr_q             <= ptr_next;
                hist_q[grant_idx] <= new_hist;
                fill_q[grant_idx] <= new_fill;
            end
            if (match) begin
                det_ch <= grant_idx;
                if (match_cnt != '1) match_cnt <= match_cnt + CW'(1);
            end
            // No grant can coincide with a config write, so this clear never races a history update.
            if (cfg_legal) begin
                pat_q     <= cfg_pattern;
                len_q     <= cfg_len;
                det_ch    <= '0;
                match_cnt <= '0;
                for (int c = 0; c < NCH; c++) begin
                    hist_q[c] <= '0;
                    fill_q[c] <= '0;
                end
            end
        end
    end

endmodule
